// File: rtl/imem_ctrl_pkg.sv
// Shared types and constants for the byte-serial instruction fetch controller.
// Vectors use ascending ranges so that bit 0 is the MSB, matching the memory interface.
package imem_ctrl_pkg;

  localparam int unsigned MemBytes = 2048;
  localparam int unsigned AddrW    = 11;
  localparam int unsigned WordW    = 32;

  typedef enum logic [1:0] {
    StFetch,
    StDrain,
    StHold,
    StFault
  } fetch_state_e;

  // A fetch target is legal only when word aligned with all four bytes inside memory.
  function automatic logic pc_illegal(input logic [0:WordW-1] pc, input int unsigned mem_bytes);
    logic [0:WordW] last_byte;
    last_byte = {1'b0, pc} + 33'd3;
    return (pc[WordW-2:WordW-1] != 2'b00) || (last_byte >= {1'b0, mem_bytes});
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Collects four big-endian bytes into one 32-bit instruction word (bit 0 is the MSB).
module imem_word_assembler (
  input  logic        clk,
  input  logic        reset,
  input  logic [0:7]  data_byte,
  input  logic [1:0]  byte_idx,
  input  logic        load,
  input  logic        clear,
  output logic [0:31] word
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      word <= 32'h0000_0000;
    end else if (load) begin
      case (byte_idx)
        2'd0:    word[0:7]   <= data_byte;
        2'd1:    word[8:15]  <= data_byte;
        2'd2:    word[16:23] <= data_byte;
        default: word[24:31] <= data_byte;
      endcase
    end
  end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetches 32-bit instructions one byte per cycle from a byte-wide memory with
// one-cycle read latency, presents them with a valid/ready handshake, and handles redirects.
module imem_fetch_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter logic [0:31] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = MemBytes
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [0:31] redirect_addr,
  input  logic        instr_ready,
  output logic        instr_valid,
  output logic [0:31] instr,
  output logic [0:31] instr_pc,
  output logic        mem_rd_en,
  output logic [0:10] mem_addr,
  input  logic [0:7]  mem_rdata,
  output logic        fault
);

  fetch_state_e     state_q;
  logic [1:0]       cnt_q;
  logic [1:0]       issue_idx_q;
  logic [1:0]       pend_idx_q;
  logic [0:31]      pc_q;
  logic [0:31]      instr_pc_q;
  logic [0:AddrW-1] addr_q;
  logic             rd_en_q;
  logic             pend_q;
  logic             instr_valid_q;
  logic             fault_q;

  logic             handshake;
  logic             redirect;
  logic             start;
  logic             capture;
  logic [0:31]      start_pc;

  always_comb begin
    handshake = (state_q == StHold) && instr_valid_q && instr_ready;
    redirect  = redirect_valid && (state_q != StFault);
    // StFetch with cnt=0 only occurs right after reset; every other fetch starts on a transition.
    start     = redirect || handshake || ((state_q == StFetch) && (cnt_q == 2'd0));
    start_pc  = redirect ? redirect_addr : (handshake ? pc_q + 32'd4 : pc_q);
    // A byte arriving on a start edge belongs to the abandoned word.
    capture   = pend_q && !start;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StFetch;
      cnt_q         <= 2'd0;
      issue_idx_q   <= 2'd0;
      pend_idx_q    <= 2'd0;
      pc_q          <= RESET_PC;
      instr_pc_q    <= 32'h0000_0000;
      addr_q        <= '0;
      rd_en_q       <= 1'b0;
      pend_q        <= 1'b0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      rd_en_q    <= 1'b0;
      pend_q     <= rd_en_q && !start;
      pend_idx_q <= issue_idx_q;
      if (start) begin
        pc_q          <= start_pc;
        cnt_q         <= 2'd1;
        instr_valid_q <= 1'b0;
        if (pc_illegal(start_pc, MEM_BYTES)) begin
          state_q <= StFault;
          fault_q <= 1'b1;
        end else begin
          state_q     <= StFetch;
          rd_en_q     <= 1'b1;
          addr_q      <= start_pc[21:31];
          issue_idx_q <= 2'd0;
        end
      end else begin
        case (state_q)
          StFetch: begin
            rd_en_q     <= 1'b1;
            addr_q      <= pc_q[21:31] + {9'd0, cnt_q};
            issue_idx_q <= cnt_q;
            cnt_q       <= cnt_q + 2'd1;
            if (cnt_q == 2'd3) state_q <= StDrain;
          end
          StDrain: begin
            if (capture && (pend_idx_q == 2'd3)) begin
              state_q       <= StHold;
              instr_valid_q <= 1'b1;
              instr_pc_q    <= pc_q;
            end
          end
          default: ;
        endcase
      end
    end
  end

  imem_word_assembler u_asm (
    .clk       (clk),
    .reset     (reset),
    .data_byte (mem_rdata),
    .byte_idx  (pend_idx_q),
    .load      (capture),
    .clear     (start),
    .word      (instr)
  );

  assign instr_valid = instr_valid_q;
  assign instr_pc    = instr_pc_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_addr    = addr_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a byte-wide one-cycle-latency memory model.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [0:31] redirect_addr;
  logic        instr_ready;
  logic        instr_valid;
  logic [0:31] instr;
  logic [0:31] instr_pc;
  logic        mem_rd_en;
  logic [0:10] mem_addr;
  logic [0:7]  mem_rdata;
  logic        fault;

  logic        bad_instr_valid;
  logic [0:31] bad_instr;
  logic [0:31] bad_instr_pc;
  logic        bad_mem_rd_en;
  logic [0:10] bad_mem_addr;
  logic        bad_fault;

  logic [7:0]  mem [0:2047];
  int          total = 0;
  int          bad = 0;
  int          accepts = 0;

  always #5 clk = ~clk;

  imem_fetch_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .instr_ready    (instr_ready),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .mem_rd_en      (mem_rd_en),
    .mem_addr       (mem_addr),
    .mem_rdata      (mem_rdata),
    .fault          (fault)
  );

  // Misaligned reset PC: must fault straight out of reset.
  imem_fetch_ctrl #(.RESET_PC(32'h0000_0006)) dut_bad (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .instr_ready    (instr_ready),
    .instr_valid    (bad_instr_valid),
    .instr          (bad_instr),
    .instr_pc       (bad_instr_pc),
    .mem_rd_en      (bad_mem_rd_en),
    .mem_addr       (bad_mem_addr),
    .mem_rdata      (mem_rdata),
    .fault          (bad_fault)
  );

  // 0xEE on idle cycles exposes any capture at the wrong time.
  always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : 8'hEE;

  always @(posedge clk) if (!reset && instr_valid && instr_ready) accepts++;

  task automatic do_reset();
    reset = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr = 32'h0;
    instr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int n);
    n = -1;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (instr_valid) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({instr_valid, mem_rd_en, fault} !== 3'b000) begin
      bad++; $display("FAIL reset_flags: got %b exp 000", {instr_valid, mem_rd_en, fault}); end
    total++; if (instr !== 32'h0 || instr_pc !== 32'h0 || mem_addr !== 11'h0) begin
      bad++; $display("FAIL reset_regs: got instr=%h pc=%h addr=%h exp zeros", instr, instr_pc,
                      mem_addr); end
    total++; if (bad_fault !== 1'b0) begin
      bad++; $display("FAIL reset_bad_fault: got %b exp 0", bad_fault); end
    step();
    total++; if (mem_rd_en !== 1'b1 || mem_addr !== 11'h0) begin
      bad++; $display("FAIL first_issue: got en=%b addr=%h exp en=1 addr=000", mem_rd_en,
                      mem_addr); end
    total++; if (bad_fault !== 1'b1 || bad_mem_rd_en !== 1'b0) begin
      bad++; $display("FAIL reset_pc_fault: got fault=%b en=%b exp fault=1 en=0", bad_fault,
                      bad_mem_rd_en); end
  endtask

  task automatic test_first_word();
    int n;
    do_reset();
    instr_ready = 1'b1;
    step();
    wait_valid(n);
    total++; if (n !== 5) begin
      bad++; $display("FAIL first_latency: got %0d exp 5", n); end
    total++; if (instr !== 32'h2008_0005 || instr_pc !== 32'h0) begin
      bad++; $display("FAIL first_word: got %h@%h exp 20080005@00000000", instr, instr_pc); end
  endtask

  task automatic test_back_to_back();
    int n;
    step();
    total++; if (instr_valid !== 1'b0 || mem_rd_en !== 1'b1 || mem_addr !== 11'h004) begin
      bad++; $display("FAIL b2b_issue: got v=%b en=%b addr=%h exp v=0 en=1 addr=004",
                      instr_valid, mem_rd_en, mem_addr); end
    wait_valid(n);
    total++; if (n !== 5) begin
      bad++; $display("FAIL b2b_period: got %0d exp 5", n); end
    total++; if (instr !== 32'h1122_3344 || instr_pc !== 32'h4) begin
      bad++; $display("FAIL b2b_word: got %h@%h exp 11223344@00000004", instr, instr_pc); end
    instr_ready = 1'b0;
  endtask

  task automatic test_stall();
    int n;
    int errs;
    do_reset();
    step();
    wait_valid(n);
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (instr !== 32'h2008_0005 || instr_pc !== 32'h0 || instr_valid !== 1'b1 ||
          mem_rd_en !== 1'b0) errs++;
    end
    total++; if (errs !== 0) begin
      bad++; $display("FAIL stall_hold: got %0d unstable cycles exp 0", errs); end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    total++; if (instr_valid !== 1'b0 || mem_rd_en !== 1'b1 || mem_addr !== 11'h004) begin
      bad++; $display("FAIL stall_release: got v=%b en=%b addr=%h exp v=0 en=1 addr=004",
                      instr_valid, mem_rd_en, mem_addr); end
  endtask

  task automatic test_redirect_mid();
    int n;
    int errs;
    logic [0:10] exp_addr;
    do_reset();
    instr_ready = 1'b1;
    step();
    step();
    step();
    total++; if (mem_addr !== 11'h002) begin
      bad++; $display("FAIL redir_cnt2: got %h exp 002", mem_addr); end
    redirect_valid = 1'b1;
    redirect_addr = 32'h40;
    errs = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      redirect_valid = 1'b0;
      exp_addr = 11'h040 + 11'(i);
      if (mem_rd_en !== 1'b1 || mem_addr !== exp_addr || instr_valid !== 1'b0) errs++;
    end
    total++; if (errs !== 0) begin
      bad++; $display("FAIL redir_addr_seq: got %0d wrong cycles exp 0", errs); end
    wait_valid(n);
    total++; if (instr !== 32'hA1B2_C3D4 || instr_pc !== 32'h40) begin
      bad++; $display("FAIL redir_word: got %h@%h exp a1b2c3d4@00000040", instr, instr_pc); end
    instr_ready = 1'b0;
  endtask

  task automatic test_redirect_handshake();
    int n;
    int a0;
    do_reset();
    step();
    wait_valid(n);
    a0 = accepts;
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr = 32'h100;
    step();
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    total++; if (instr_valid !== 1'b0 || mem_addr !== 11'h100 || mem_rd_en !== 1'b1) begin
      bad++; $display("FAIL hs_redir_issue: got v=%b en=%b addr=%h exp v=0 en=1 addr=100",
                      instr_valid, mem_rd_en, mem_addr); end
    wait_valid(n);
    total++; if (instr !== 32'h0F1E_2D3C || instr_pc !== 32'h100) begin
      bad++; $display("FAIL hs_redir_word: got %h@%h exp 0f1e2d3c@00000100", instr, instr_pc); end
    step();
    total++; if (accepts - a0 !== 1) begin
      bad++; $display("FAIL hs_redir_accepts: got %0d exp 1", accepts - a0); end
  endtask

  task automatic test_fault_misaligned();
    int errs;
    do_reset();
    step();
    redirect_valid = 1'b1;
    redirect_addr = 32'h6;
    step();
    total++; if (fault !== 1'b1 || mem_rd_en !== 1'b0 || instr_valid !== 1'b0) begin
      bad++; $display("FAIL misalign_fault: got f=%b en=%b v=%b exp f=1 en=0 v=0", fault,
                      mem_rd_en, instr_valid); end
    redirect_addr = 32'h0;
    errs = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      redirect_valid = 1'b0;
      if (fault !== 1'b1 || mem_rd_en !== 1'b0 || instr_valid !== 1'b0) errs++;
    end
    total++; if (errs !== 0) begin
      bad++; $display("FAIL fault_sticky: got %0d escaped cycles exp 0", errs); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (fault !== 1'b0) begin
      bad++; $display("FAIL fault_clear: got %b exp 0", fault); end
    step();
    total++; if (mem_rd_en !== 1'b1 || mem_addr !== 11'h000) begin
      bad++; $display("FAIL fault_refetch: got en=%b addr=%h exp en=1 addr=000", mem_rd_en,
                      mem_addr); end
  endtask

  task automatic test_fault_range();
    int n;
    do_reset();
    step();
    redirect_valid = 1'b1;
    redirect_addr = 32'd2044;
    step();
    redirect_valid = 1'b0;
    total++; if (mem_addr !== 11'h7FC || fault !== 1'b0) begin
      bad++; $display("FAIL top_issue: got addr=%h f=%b exp addr=7fc f=0", mem_addr, fault); end
    wait_valid(n);
    total++; if (instr !== 32'hDEAD_BEEF || instr_pc !== 32'h7FC) begin
      bad++; $display("FAIL top_word: got %h@%h exp deadbeef@000007fc", instr, instr_pc); end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    total++; if (fault !== 1'b1 || mem_rd_en !== 1'b0) begin
      bad++; $display("FAIL range_fault: got f=%b en=%b exp f=1 en=0", fault, mem_rd_en); end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++; if (mem_rd_en !== 1'b0 || mem_addr !== 11'h0 || instr !== 32'h0) begin
      bad++; $display("FAIL midreset_clear: got en=%b addr=%h instr=%h exp zeros", mem_rd_en,
                      mem_addr, instr); end
    step();
    wait_valid(n);
    total++; if (n !== 5 || instr !== 32'h2008_0005) begin
      bad++; $display("FAIL midreset_word: got n=%0d %h exp n=5 20080005", n, instr); end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 8'h00;
    {mem[0], mem[1], mem[2], mem[3]} = 32'h2008_0005;
    {mem[4], mem[5], mem[6], mem[7]} = 32'h1122_3344;
    {mem[64], mem[65], mem[66], mem[67]} = 32'hA1B2_C3D4;
    {mem[256], mem[257], mem[258], mem[259]} = 32'h0F1E_2D3C;
    {mem[2044], mem[2045], mem[2046], mem[2047]} = 32'hDEAD_BEEF;

    test_reset();
    test_first_word();
    test_back_to_back();
    test_stall();
    test_redirect_mid();
    test_redirect_handshake();
    test_fault_misaligned();
    test_fault_range();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule
